reg_arb: RTL and testbench

REG_ARB -- requirements
Module: reg_arb

---
 rtl/reg_arb.sv | 142 ++++++++++++++
 tb/tb_reg_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_arb.sv
// reg_arb: two-requester round-robin arbiter in front of a small register
// group (A, B, C). Each granted access walks IDLE -> SETUP -> ACCESS -> DONE;
// an access to address 11 skips straight to DONE with an error flag.
module reg_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic [1:0] rf_raa,
    output logic [1:0] rf_rwba,
    output logic       rf_we_n,
    output logic [7:0] rf_i,
    input  logic [7:0] rf_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    state_t     state;
    logic       last_gnt;   // requester granted most recently
    logic       gnt;        // requester owning the current access
    logic       lat_rw;     // latched direction of the current access

    logic       win;
    logic       win_rw;
    logic [1:0] win_addr;
    logic [7:0] win_wdata;

    // Round-robin pick between the two requesters and mux the winner's fields.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_gnt;
        end else if (req1) begin
            win = 1'b1;
        end
        win_rw    = win ? rw1    : rw0;
        win_addr  = win ? addr1  : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    // Access sequencer: state plus every output, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            lat_rw   <= 1'b0;
            busy     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0   <= 8'h00;
            rdata1   <= 8'h00;
            rf_raa   <= 2'b00;
            rf_rwba  <= 2'b00;
            rf_i     <= 8'h00;
            rf_we_n  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let these pulse defaults be
            // overridden later in the same block without ordering hazards.
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rf_we_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt    <= win;
                        lat_rw <= win_rw;
                        busy   <= 1'b1;
                        if (win_addr == ADDR_INVALID) begin
                            // Rejected access: complete at once, register
                            // group and rdata untouched.
                            state    <= DONE;
                            last_gnt <= win;
                            if (win) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end else begin
                            state   <= SETUP;
                            rf_raa  <= win_addr;
                            rf_rwba <= win_addr;
                            rf_i    <= win_wdata;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    rf_we_n <= ~lat_rw;
                end
                ACCESS: begin
                    state    <= DONE;
                    last_gnt <= gnt;
                    if (gnt) begin
                        ack1 <= 1'b1;
                        if (!lat_rw) rdata1 <= rf_d;
                    end else begin
                        ack0 <= 1'b1;
                        if (!lat_rw) rdata0 <= rf_d;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_arb.sv
// tb_reg_arb: directed bench for reg_arb with a behavioural register group
// that commits writes on the falling clock edge.
module tb_reg_arb;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, rw0, rw1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       busy;
    logic [1:0] rf_raa, rf_rwba;
    logic       rf_we_n;
    logic [7:0] rf_i;
    logic [7:0] rf_d;

    int total = 0;
    int bad   = 0;

    logic [7:0] rf_mem [0:3];

    reg_arb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .rw0     (rw0),
        .rw1     (rw1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack0    (ack0),
        .ack1    (ack1),
        .err0    (err0),
        .err1    (err1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .busy    (busy),
        .rf_raa  (rf_raa),
        .rf_rwba (rf_rwba),
        .rf_we_n (rf_we_n),
        .rf_i    (rf_i),
        .rf_d    (rf_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register group: write commits on the falling edge while rf_we_n is low.
    always @(negedge clk) begin
        if (rf_we_n === 1'b0) rf_mem[rf_rwba] <= rf_i;
    end
    assign rf_d = rf_mem[rf_rwba];

    localparam logic [33:0] RESET_OUTS = {1'b1, 2'b00, 2'b00, 8'h00, 1'b0, 4'b0000, 8'h00, 8'h00};

    function automatic logic [33:0] outs();
        return {rf_we_n, rf_raa, rf_rwba, rf_i, busy, ack0, ack1, err0, err1, rdata0, rdata1};
    endfunction

    // Drive one access from IDLE, watch for its ack, return to IDLE.
    task automatic run_access(input bit who, input bit rw, input logic [1:0] addr,
                              input logic [7:0] data, output int lat, output bit got,
                              output bit err_at, output logic [7:0] rd_at,
                              output bit other_ack, output int we_cyc);
        lat = 0; got = 0; err_at = 0; rd_at = 8'h00; other_ack = 0; we_cyc = 0;
        if (who == 1'b0) begin
            rw0 = rw; addr0 = addr; wdata0 = data; req0 = 1'b1;
        end else begin
            rw1 = rw; addr1 = addr; wdata1 = data; req1 = 1'b1;
        end
        for (int n = 1; n <= 12 && !got; n++) begin
            @(posedge clk); #1;
            if (rf_we_n === 1'b0) we_cyc++;
            if ((who == 1'b0) ? (ack1 === 1'b1) : (ack0 === 1'b1)) other_ack = 1;
            if ((who == 1'b0) ? (ack0 === 1'b1) : (ack1 === 1'b1)) begin
                got    = 1;
                lat    = n;
                err_at = (who == 1'b0) ? err0 : err1;
                rd_at  = (who == 1'b0) ? rdata0 : rdata1;
            end
        end
        if (who == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rf_mem[0] = 8'h11; rf_mem[1] = 8'h22; rf_mem[2] = 8'h33; rf_mem[3] = 8'h44;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (outs() !== RESET_OUTS) begin
            bad++; $display("FAIL reset_outs: got %h want %h", outs(), RESET_OUTS);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_write_read;
        int lat, wc; bit got, er, oa; logic [7:0] rd;
        run_access(1'b0, 1'b1, 2'b01, 8'hA5, lat, got, er, rd, oa, wc);
        total++;
        if (!got || lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d (ack=%0d) want 3", lat, got); end
        total++;
        if (wc !== 1) begin bad++; $display("FAIL wr_we_cycles: got %0d want 1", wc); end
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", er); end
        total++;
        if (rf_mem[1] !== 8'hA5) begin bad++; $display("FAIL wr_commit: got %h want a5", rf_mem[1]); end
        run_access(1'b0, 1'b0, 2'b01, 8'h00, lat, got, er, rd, oa, wc);
        total++;
        if (!got || lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d (ack=%0d) want 3", lat, got); end
        total++;
        if (rd !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", rd); end
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", er); end
        total++;
        if (wc !== 0) begin bad++; $display("FAIL rd_we_cycles: got %0d want 0", wc); end
        total++;
        if (rdata0 !== 8'hA5) begin bad++; $display("FAIL rd_hold: got %h want a5", rdata0); end
    endtask

    task automatic test_isolation;
        int lat, wc; bit got, er, oa; logic [7:0] rd;
        run_access(1'b1, 1'b0, 2'b00, 8'h5A, lat, got, er, rd, oa, wc);
        total++;
        if (!got || lat !== 3) begin bad++; $display("FAIL iso_latency: got %0d (ack=%0d) want 3", lat, got); end
        total++;
        if (rd !== 8'h11) begin bad++; $display("FAIL iso_rdata1: got %h want 11", rd); end
        total++;
        if (oa !== 1'b0) begin bad++; $display("FAIL iso_ack0: got %b want 0", oa); end
        total++;
        if (rdata0 !== 8'hA5) begin bad++; $display("FAIL iso_rdata0: got %h want a5", rdata0); end
    endtask

    task automatic test_invalid;
        int lat, wc; bit got, er, oa; logic [7:0] rd;
        run_access(1'b1, 1'b1, 2'b11, 8'hFF, lat, got, er, rd, oa, wc);
        total++;
        if (!got || lat !== 1) begin bad++; $display("FAIL inv_latency: got %0d (ack=%0d) want 1", lat, got); end
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL inv_err: got %b want 1", er); end
        total++;
        if (wc !== 0) begin bad++; $display("FAIL inv_we_cycles: got %0d want 0", wc); end
        total++;
        if (oa !== 1'b0) begin bad++; $display("FAIL inv_other_ack: got %b want 0", oa); end
        total++;
        if ({rf_raa, rf_rwba, rf_i} !== {2'b00, 2'b00, 8'h5A}) begin
            bad++; $display("FAIL inv_rf_hold: got %h want 05a", {rf_raa, rf_rwba, rf_i});
        end
        total++;
        if (rdata1 !== 8'h11) begin bad++; $display("FAIL inv_rdata1: got %h want 11", rdata1); end
        total++;
        if (rf_mem[3] !== 8'h44) begin bad++; $display("FAIL inv_no_write: got %h want 44", rf_mem[3]); end
    endtask

    task automatic test_contention;
        int  gcyc [4];
        bit  gwho [4];
        int  ng  = 0;
        int  cyc = 0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        rw0 = 0; addr0 = 2'b00; rw1 = 0; addr1 = 2'b01;
        req0 = 1; req1 = 1;
        rst_n = 1'b1;
        while (ng < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!req0) req0 = 1'b1;
            if (!req1) req1 = 1'b1;
            if (ack0 === 1'b1 && ng < 4) begin gwho[ng] = 0; gcyc[ng] = cyc; ng++; req0 = 1'b0; end
            if (ack1 === 1'b1 && ng < 4) begin gwho[ng] = 1; gcyc[ng] = cyc; ng++; req1 = 1'b0; end
        end
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        total++;
        if (ng !== 4) begin bad++; $display("FAIL cont_grants: got %0d want 4", ng); end
        for (int i = 0; i < ng; i++) begin
            total++;
            if (gwho[i] !== 1'(i % 2)) begin
                bad++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, gwho[i], i % 2);
            end
            total++;
            if (gcyc[i] !== 3 + 4 * i) begin
                bad++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, gcyc[i], 3 + 4 * i);
            end
        end
    endtask

    task automatic test_abort;
        int lat, wc; bit got, er, oa; logic [7:0] rd;
        bit seen;
        run_access(1'b0, 1'b1, 2'b10, 8'h77, lat, got, er, rd, oa, wc);
        total++;
        if (!got || lat !== 3) begin bad++; $display("FAIL abort_preload: got %0d (ack=%0d) want 3", lat, got); end
        rw0 = 1; addr0 = 2'b10; wdata0 = 8'h3C; req0 = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (rf_we_n !== 1'b0) begin bad++; $display("FAIL abort_in_access: got %b want 0", rf_we_n); end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs() !== RESET_OUTS) begin
            bad++; $display("FAIL abort_reset_outs: got %h want %h", outs(), RESET_OUTS);
        end
        req0 = 0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack0 === 1'b1) seen = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack0 === 1'b1) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_ack: got %b want 0", seen); end
        run_access(1'b0, 1'b0, 2'b10, 8'h00, lat, got, er, rd, oa, wc);
        total++;
        if (!got || rd !== 8'h77) begin bad++; $display("FAIL abort_readback: got %h (ack=%0d) want 77", rd, got); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_isolation();
        test_invalid();
        test_contention();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
